// File: rtl/stage_m.sv
// stage_m: MIPS memory stage -- data-memory access with store bypass, load extraction,
// alignment exceptions and the M/W pipeline register.
`ifndef STAGE_M_DEFS
`define STAGE_M_DEFS
`define TYPE_INSTR logic [5:0]
`define TYPE_IFUNC logic [3:0]
`define TYPE_EXC   logic [4:0]
`define TYPE_T     logic [1:0]
`define INSTR_NOP  6'd0
`define INSTR_LB   6'd1
`define INSTR_LBU  6'd2
`define INSTR_LH   6'd3
`define INSTR_LHU  6'd4
`define INSTR_LW   6'd5
`define INSTR_SB   6'd6
`define INSTR_SH   6'd7
`define INSTR_SW   6'd8
`define INSTR_ADDU 6'd9
`define I_NONE     4'd0
`define I_ALU      4'd1
`define I_MEM_R    4'd2
`define I_MEM_W    4'd3
`define EXC_ADEL   5'd4
`define EXC_ADES   5'd5
`endif

module stage_m (
    input  logic        clk,
    input  logic        reset,
    input  `TYPE_INSTR  instr_M,
    input  `TYPE_IFUNC  ifunc_M,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  `TYPE_EXC    exc_M,
    input  logic [4:0]  addrRt_M,
    input  logic [31:0] dataRt_M,
    input  logic [31:0] aluOut_M,
    input  logic        regWEn_M,
    input  logic [4:0]  regWAddr_M,
    input  logic [31:0] regWData_M,
    input  logic        regWValid_M,
    input  `TYPE_T      Tnew_M,
    output logic [31:0] dmAddr,
    output logic [3:0]  dmByteEn,
    output logic [31:0] dmWData,
    input  logic [31:0] dmRData,
    output `TYPE_EXC    exc,
    output `TYPE_INSTR  instr_W,
    output logic [31:0] PC_W,
    output logic        BD_W,
    output `TYPE_EXC    exc_W,
    output logic        regWEn_W,
    output logic [4:0]  regWAddr_W,
    output logic [31:0] regWData_W,
    output logic        regWValid_W,
    output `TYPE_T      Tnew_W,
    input  logic        stall,
    input  logic        clear
);
    logic [1:0]  offset;
    logic        isLoad, isStore, isWord, isHalf, misaligned, memRead;
    logic [31:0] storeData, loadData, nextWData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    `TYPE_T      nextTnew;

    always_comb begin
        offset = aluOut_M[1:0];
        isLoad = instr_M inside {`INSTR_LB, `INSTR_LBU, `INSTR_LH, `INSTR_LHU, `INSTR_LW};
        isStore = instr_M inside {`INSTR_SB, `INSTR_SH, `INSTR_SW};
        isWord = instr_M inside {`INSTR_LW, `INSTR_SW};
        isHalf = instr_M inside {`INSTR_LH, `INSTR_LHU, `INSTR_SH};
        misaligned = (isWord && offset != 2'b00) || (isHalf && offset[0]);
        exc = exc_M != '0 ? exc_M :
              misaligned && isLoad ? `EXC_ADEL :
              misaligned && isStore ? `EXC_ADES : '0;
        // W is the only bypass source still pending at this point for the store data
        storeData = regWEn_W && regWAddr_W != 5'd0 && regWAddr_W == addrRt_M ? regWData_W : dataRt_M;
        dmAddr = {aluOut_M[31:2], 2'b00};
        dmByteEn = instr_M == `INSTR_SW ? 4'b1111 :
                   instr_M == `INSTR_SH ? (offset[1] ? 4'b1100 : 4'b0011) :
                   instr_M == `INSTR_SB ? 4'b0001 << offset : 4'b0000;
        if (exc != '0 || stall || clear)
            dmByteEn = 4'b0000;
        dmWData = instr_M == `INSTR_SH ? {2{storeData[15:0]}} :
                  instr_M == `INSTR_SB ? {4{storeData[7:0]}} : storeData;
        loadByte = dmRData[{offset, 3'b000} +: 8];
        loadHalf = offset[1] ? dmRData[31:16] : dmRData[15:0];
        loadData = instr_M == `INSTR_LB  ? {{24{loadByte[7]}}, loadByte} :
                   instr_M == `INSTR_LBU ? {24'd0, loadByte} :
                   instr_M == `INSTR_LH  ? {{16{loadHalf[15]}}, loadHalf} :
                   instr_M == `INSTR_LHU ? {16'd0, loadHalf} : dmRData;
        memRead = ifunc_M == `I_MEM_R;
        nextWData = memRead ? loadData : regWData_M;
        nextTnew = Tnew_M != '0 ? Tnew_M - 2'd1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_W     <= '0;
            PC_W        <= '0;
            BD_W        <= 1'b0;
            exc_W       <= '0;
            regWEn_W    <= 1'b0;
            regWAddr_W  <= '0;
            regWData_W  <= '0;
            regWValid_W <= 1'b0;
            Tnew_W      <= '0;
        end else if (!stall) begin
            instr_W     <= clear ? '0 : instr_M;
            PC_W        <= clear ? '0 : PC_M;
            BD_W        <= clear ? 1'b0 : BD_M;
            exc_W       <= clear ? '0 : exc;
            regWEn_W    <= clear ? 1'b0 : regWEn_M && exc == '0;
            regWAddr_W  <= clear ? '0 : regWAddr_M;
            regWData_W  <= clear ? '0 : nextWData;
            regWValid_W <= clear ? 1'b0 : regWValid_M || memRead;
            Tnew_W      <= clear ? '0 : nextTnew;
        end
    end
endmodule

// File: tb/tb_stage_m.sv
// tb_stage_m: scoreboard bench for stage_m; expected W bundles are queued as stimulus is
// driven and retired one per clock edge.
`ifndef STAGE_M_DEFS
`define STAGE_M_DEFS
`define TYPE_INSTR logic [5:0]
`define TYPE_IFUNC logic [3:0]
`define TYPE_EXC   logic [4:0]
`define TYPE_T     logic [1:0]
`define INSTR_NOP  6'd0
`define INSTR_LB   6'd1
`define INSTR_LBU  6'd2
`define INSTR_LH   6'd3
`define INSTR_LHU  6'd4
`define INSTR_LW   6'd5
`define INSTR_SB   6'd6
`define INSTR_SH   6'd7
`define INSTR_SW   6'd8
`define INSTR_ADDU 6'd9
`define I_NONE     4'd0
`define I_ALU      4'd1
`define I_MEM_R    4'd2
`define I_MEM_W    4'd3
`define EXC_ADEL   5'd4
`define EXC_ADES   5'd5
`endif

module tb_stage_m;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  instr_M;
    logic [3:0]  ifunc_M;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [4:0]  exc_M;
    logic [4:0]  addrRt_M;
    logic [31:0] dataRt_M, aluOut_M;
    logic        regWEn_M;
    logic [4:0]  regWAddr_M;
    logic [31:0] regWData_M;
    logic        regWValid_M;
    logic [1:0]  Tnew_M;
    logic [31:0] dmAddr, dmWData, dmRData;
    logic [3:0]  dmByteEn;
    logic [4:0]  exc;
    logic [5:0]  instr_W;
    logic [31:0] PC_W;
    logic        BD_W;
    logic [4:0]  exc_W;
    logic        regWEn_W;
    logic [4:0]  regWAddr_W;
    logic [31:0] regWData_W;
    logic        regWValid_W;
    logic [1:0]  Tnew_W;
    logic        stall = 1'b0, clear = 1'b0;

    typedef logic [84:0] wvec_t;
    wvec_t expQ[$];
    wvec_t wNow;
    int compared = 0;
    int mismatched = 0;

    assign wNow = {instr_W, PC_W, BD_W, exc_W, regWEn_W, regWAddr_W, regWData_W, regWValid_W, Tnew_W};

    always #5 clk = ~clk;

    stage_m dut (
        .clk(clk), .reset(reset),
        .instr_M(instr_M), .ifunc_M(ifunc_M), .PC_M(PC_M), .BD_M(BD_M), .exc_M(exc_M),
        .addrRt_M(addrRt_M), .dataRt_M(dataRt_M), .aluOut_M(aluOut_M),
        .regWEn_M(regWEn_M), .regWAddr_M(regWAddr_M), .regWData_M(regWData_M),
        .regWValid_M(regWValid_M), .Tnew_M(Tnew_M),
        .dmAddr(dmAddr), .dmByteEn(dmByteEn), .dmWData(dmWData), .dmRData(dmRData), .exc(exc),
        .instr_W(instr_W), .PC_W(PC_W), .BD_W(BD_W), .exc_W(exc_W),
        .regWEn_W(regWEn_W), .regWAddr_W(regWAddr_W), .regWData_W(regWData_W),
        .regWValid_W(regWValid_W), .Tnew_W(Tnew_W),
        .stall(stall), .clear(clear)
    );

    function automatic wvec_t mk(logic [5:0] i, logic [31:0] pc, logic bd, logic [4:0] e, logic en,
                                 logic [4:0] a, logic [31:0] d, logic v, logic [1:0] t);
        return {i, pc, bd, e, en, a, d, v, t};
    endfunction

    task automatic drive(logic [5:0] i, logic [3:0] f, logic [31:0] pc, logic bd, logic [4:0] e,
                         logic [4:0] rt, logic [31:0] drt, logic [31:0] alu, logic en,
                         logic [4:0] wa, logic [31:0] wd, logic wv, logic [1:0] t, logic [31:0] rd);
        instr_M = i; ifunc_M = f; PC_M = pc; BD_M = bd; exc_M = e;
        addrRt_M = rt; dataRt_M = drt; aluOut_M = alu;
        regWEn_M = en; regWAddr_M = wa; regWData_M = wd; regWValid_M = wv; Tnew_M = t; dmRData = rd;
    endtask

    // Advance one clock; the registered W bundle is scored against the oldest queued expectation.
    task automatic tick();
        wvec_t e;
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            compared++;
            if (wNow !== e) begin
                mismatched++;
                $display("FAIL w_regs got=%h expected=%h", wNow, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(`INSTR_NOP, `I_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        compared++;
        if (exc !== 5'd0) begin mismatched++; $display("FAIL reset_exc got=%h expected=0", exc); end
        expQ.push_back('0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_store();
        logic [5:0]  ins [6] = '{`INSTR_SB, `INSTR_SB, `INSTR_SB, `INSTR_SH, `INSTR_SH, `INSTR_SW};
        logic [31:0] alu [6] = '{32'h1003, 32'h1000, 32'h1001, 32'h1002, 32'h1000, 32'h1004};
        logic [31:0] adr [6] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
        logic [3:0]  ben [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
        logic [31:0] wd  [6] = '{32'hDDDDDDDD, 32'hDDDDDDDD, 32'hDDDDDDDD, 32'hCCDDCCDD, 32'hCCDDCCDD, 32'hAABBCCDD};
        for (int k = 0; k < 6; k++) begin
            drive(ins[k], `I_MEM_W, 32'h400 + k * 4, 0, 0, 5'd7, 32'hAABBCCDD, alu[k], 0, 0, 0, 0, 0, 0);
            #1;
            compared += 4;
            if (dmAddr !== adr[k]) begin mismatched++; $display("FAIL store_addr[%0d] got=%h expected=%h", k, dmAddr, adr[k]); end
            if (dmByteEn !== ben[k]) begin mismatched++; $display("FAIL store_byteen[%0d] got=%b expected=%b", k, dmByteEn, ben[k]); end
            if (dmWData !== wd[k]) begin mismatched++; $display("FAIL store_wdata[%0d] got=%h expected=%h", k, dmWData, wd[k]); end
            if (exc !== 5'd0) begin mismatched++; $display("FAIL store_exc[%0d] got=%h expected=0", k, exc); end
            expQ.push_back(mk(ins[k], 32'h400 + k * 4, 0, 0, 0, 0, 0, 0, 0));
            tick();
        end
    endtask

    task automatic test_load();
        logic [5:0]  ins [6] = '{`INSTR_LH, `INSTR_LHU, `INSTR_LH, `INSTR_LB, `INSTR_LBU, `INSTR_LW};
        logic [31:0] alu [6] = '{32'h2002, 32'h2002, 32'h2000, 32'h2001, 32'h2003, 32'h2004};
        logic [31:0] rd  [6] = '{32'h8001FFFF, 32'h8001FFFF, 32'h8001FFFF, 32'h123480FF, 32'h123480FF, 32'h0BADCAFE};
        logic [31:0] ev  [6] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFFFF, 32'hFFFFFF80, 32'h00000012, 32'h0BADCAFE};
        for (int k = 0; k < 6; k++) begin
            drive(ins[k], `I_MEM_R, 32'h800 + k * 4, 0, 0, 5'd7, 0, alu[k], 1, 5'd9, 32'h5A5A5A5A, 0, 2'd2, rd[k]);
            #1;
            compared += 2;
            if (dmByteEn !== 4'b0000) begin mismatched++; $display("FAIL load_byteen[%0d] got=%b expected=0000", k, dmByteEn); end
            if (exc !== 5'd0) begin mismatched++; $display("FAIL load_exc[%0d] got=%h expected=0", k, exc); end
            expQ.push_back(mk(ins[k], 32'h800 + k * 4, 0, 0, 1, 5'd9, ev[k], 1, 2'd1));
            tick();
        end
    endtask

    task automatic test_misaligned();
        logic [5:0]  ins [7] = '{`INSTR_SW, `INSTR_SH, `INSTR_LW, `INSTR_LH, `INSTR_LB, `INSTR_SB, `INSTR_LW};
        logic [31:0] alu [7] = '{32'h3002, 32'h3001, 32'h3001, 32'h3003, 32'h3003, 32'h3001, 32'h3002};
        logic [4:0]  ein [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd10, 5'd12};
        logic [4:0]  eex [7] = '{`EXC_ADES, `EXC_ADES, `EXC_ADEL, `EXC_ADEL, 5'd0, 5'd10, 5'd12};
        logic [31:0] ewd [7] = '{32'h55, 32'h55, 32'hDEADBEEF, 32'hFFFFDEAD, 32'hFFFFFFDE, 32'h55, 32'hDEADBEEF};
        logic [3:0]  f;
        for (int k = 0; k < 7; k++) begin
            f = ins[k] inside {`INSTR_SB, `INSTR_SH, `INSTR_SW} ? `I_MEM_W : `I_MEM_R;
            drive(ins[k], f, 32'h3000 + k * 4, 1, ein[k], 5'd7, 32'h11, alu[k], 1, 5'd4, 32'h55, 0, 2'd2, 32'hDEADBEEF);
            #1;
            compared += 2;
            if (exc !== eex[k]) begin mismatched++; $display("FAIL align_exc[%0d] got=%h expected=%h", k, exc, eex[k]); end
            if (dmByteEn !== 4'b0000) begin mismatched++; $display("FAIL align_byteen[%0d] got=%b expected=0000", k, dmByteEn); end
            expQ.push_back(mk(ins[k], 32'h3000 + k * 4, 1, eex[k], eex[k] == 5'd0, 5'd4, ewd[k], f == `I_MEM_R, 2'd1));
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [4:0]  wa  [3] = '{5'd5, 5'd0, 5'd6};
        logic [4:0]  rt  [3] = '{5'd5, 5'd0, 5'd7};
        logic [31:0] drt [3] = '{32'h0, 32'h0, 32'h77};
        logic [31:0] ewd [3] = '{32'h12345678, 32'h0, 32'h77};
        for (int k = 0; k < 3; k++) begin
            drive(`INSTR_ADDU, `I_ALU, 32'h4000, 0, 0, 0, 0, 0, 1, wa[k], 32'h12345678, 1, 2'd1, 0);
            expQ.push_back(mk(`INSTR_ADDU, 32'h4000, 0, 0, 1, wa[k], 32'h12345678, 1, 2'd0));
            tick();
            drive(`INSTR_SW, `I_MEM_W, 32'h4004, 0, 0, rt[k], drt[k], 32'h4100, 0, 0, 0, 0, 0, 0);
            #1;
            compared += 2;
            if (dmWData !== ewd[k]) begin mismatched++; $display("FAIL bypass_wdata[%0d] got=%h expected=%h", k, dmWData, ewd[k]); end
            if (dmByteEn !== 4'b1111) begin mismatched++; $display("FAIL bypass_byteen[%0d] got=%b expected=1111", k, dmByteEn); end
            expQ.push_back(mk(`INSTR_SW, 32'h4004, 0, 0, 0, 0, 0, 0, 0));
            tick();
        end
    endtask

    task automatic test_stall_clear();
        wvec_t e1 = mk(`INSTR_ADDU, 32'h5000, 1, 0, 1, 5'd3, 32'hCAFE, 1, 2'd1);
        drive(`INSTR_ADDU, `I_ALU, 32'h5000, 1, 0, 0, 0, 0, 1, 5'd3, 32'hCAFE, 1, 2'd2, 0);
        expQ.push_back(e1);
        tick();
        drive(`INSTR_SW, `I_MEM_W, 32'h5004, 0, 0, 5'd8, 32'h99, 32'h5100, 0, 0, 0, 0, 0, 0);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            compared++;
            if (dmByteEn !== 4'b0000) begin mismatched++; $display("FAIL stall_byteen[%0d] got=%b expected=0000", k, dmByteEn); end
            expQ.push_back(e1);
            tick();
        end
        stall = 1'b0;
        clear = 1'b1;
        #1;
        compared++;
        if (dmByteEn !== 4'b0000) begin mismatched++; $display("FAIL clear_byteen got=%b expected=0000", dmByteEn); end
        expQ.push_back('0);
        tick();
        clear = 1'b0;
        drive(`INSTR_ADDU, `I_ALU, 32'h5000, 1, 0, 0, 0, 0, 1, 5'd3, 32'hCAFE, 1, 2'd2, 0);
        expQ.push_back(e1);
        tick();
        drive(`INSTR_SW, `I_MEM_W, 32'h5004, 0, 0, 5'd8, 32'h99, 32'h5100, 0, 0, 0, 0, 0, 0);
        stall = 1'b1;
        clear = 1'b1;
        expQ.push_back(e1);
        tick();
        stall = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(`INSTR_ADDU, `I_ALU, 32'h6000, 1, 0, 0, 0, 0, 1, 5'd2, 32'h6666, 1, 2'd3, 0);
        expQ.push_back(mk(`INSTR_ADDU, 32'h6000, 1, 0, 1, 5'd2, 32'h6666, 1, 2'd2));
        tick();
        reset = 1'b1;
        stall = 1'b1;
        expQ.push_back('0);
        tick();
        stall = 1'b0;
        drive(`INSTR_SW, `I_MEM_W, 32'h6004, 0, 0, 5'd8, 32'h1, 32'h6000, 0, 0, 0, 0, 0, 0);
        #1;
        compared++;
        if (dmByteEn !== 4'b1111) begin mismatched++; $display("FAIL reset_byteen got=%b expected=1111", dmByteEn); end
        expQ.push_back('0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  i;
        logic [3:0]  f;
        logic [31:0] base, rd, wd, pc, ev, sh;
        logic [1:0]  off, t;
        logic        en, bd;
        logic [4:0]  wa;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: i = `INSTR_LB;
                1: i = `INSTR_LBU;
                2: i = `INSTR_LH;
                3: i = `INSTR_LHU;
                4: i = `INSTR_LW;
                default: i = `INSTR_ADDU;
            endcase
            base = $urandom & 32'hFFFFFFFC;
            off = 2'($urandom_range(0, 3));
            if (i == `INSTR_LW) off = 2'd0;
            if (i == `INSTR_LH || i == `INSTR_LHU) off = {off[1], 1'b0};
            rd = $urandom; wd = $urandom; pc = $urandom;
            t = 2'($urandom_range(0, 3)); en = 1'($urandom_range(0, 1)); bd = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            f = i == `INSTR_ADDU ? `I_ALU : `I_MEM_R;
            sh = rd >> (8 * off);
            case (i)
                `INSTR_LB:  ev = sh[7] ? (sh | 32'hFFFFFF00) : (sh & 32'hFF);
                `INSTR_LBU: ev = sh & 32'hFF;
                `INSTR_LH:  ev = sh[15] ? (sh | 32'hFFFF0000) : (sh & 32'hFFFF);
                `INSTR_LHU: ev = sh & 32'hFFFF;
                `INSTR_LW:  ev = rd;
                default:    ev = wd;
            endcase
            drive(i, f, pc, bd, 0, 5'd0, 0, base | 32'(off), en, wa, wd, 0, t, rd);
            #1;
            compared++;
            if (dmAddr !== base) begin mismatched++; $display("FAIL b2b_addr[%0d] got=%h expected=%h", k, dmAddr, base); end
            expQ.push_back(mk(i, pc, bd, 0, en, wa, ev, f == `I_MEM_R, t == 2'd0 ? 2'd0 : t - 2'd1));
            tick();
        end
        compared++;
        if (expQ.size() != 0) begin mismatched++; $display("FAIL queue_drain got=%0d expected=0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misaligned();
        test_bypass();
        test_stall_clear();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
